// File: rtl/input_conditioner_pkg.sv
// Shared constants and sizing helper for the pin-side input conditioner.
// Latency: n/a (package only).
// Backpressure: n/a.
package input_conditioner_pkg;

  // 10 ms of stability at 100 MHz before a new level is accepted.
  localparam int unsigned DB_CYCLES_DEFAULT = 1000000;

  // Short debounce window for simulation, so tests finish in a few cycles.
  localparam int unsigned DB_CYCLES_SIM = 4;

  // Smallest counter width w with 2^w > db_cycles, so the count never wraps.
  function automatic int unsigned cnt_width(input int unsigned db_cycles);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((64'd1 << w) <= 64'(db_cycles))) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One debounced channel: synchroniser, stability counter, stable register and change strobe.
// Latency: SYNC_STAGES + DB_CYCLES clk edges from first raw sample to stable_o.
// Backpressure: none; the channel free-runs every cycle.
module debounce_channel #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             chg_o
);

  // Terminal count: the candidate has been seen DB_CYCLES times in a row.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chg_q, chg_d;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign stable_o = stable_q;
  assign chg_o    = chg_q;

  // Synchroniser chain bringing the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Stability counter: any change of the candidate restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    chg_d    = 1'b0;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (synced != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = synced;
      cnt_d    = '0;
      chg_d    = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Channel state registers; the strobe is registered alongside the new level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stable_q <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      chg_q    <= 1'b0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= synced;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Board-pin conditioner: debounced button levels, press strobes and switch value.
// Latency: SYNC_STAGES + DB_CYCLES clk edges from a clean raw edge to the outputs.
// Backpressure: none; outputs are levels and single-cycle strobes.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = cnt_width(DB_CYCLES),
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_otp_raw,
  input  logic       btn_user_raw,
  input  logic [3:0] sw_raw,
  output logic       otp_latch,
  output logic       user_latch,
  output logic       otp_press,
  output logic       user_press,
  output logic [3:0] user_in,
  output logic       sw_changed
);

  logic otp_chg;
  logic user_chg;

  debounce_channel #(
    .WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)
  ) u_otp (
    .clk(clk), .rstn(rstn), .raw_i(btn_otp_raw), .stable_o(otp_latch), .chg_o(otp_chg)
  );

  debounce_channel #(
    .WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)
  ) u_user (
    .clk(clk), .rstn(rstn), .raw_i(btn_user_raw), .stable_o(user_latch), .chg_o(user_chg)
  );

  // The switches share one counter so user_in only ever moves as a whole vector.
  debounce_channel #(
    .WIDTH(4), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)
  ) u_sw (
    .clk(clk), .rstn(rstn), .raw_i(sw_raw), .stable_o(user_in), .chg_o(sw_changed)
  );

  // A change strobe is a press only when the newly accepted level is high;
  // both terms are flop outputs, so the strobe is clean and one cycle wide.
  assign otp_press  = otp_chg & otp_latch;
  assign user_press = user_chg & user_latch;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int DB = DB_CYCLES_SIM;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       btn_otp_raw, btn_user_raw;
  logic [3:0] sw_raw;
  logic       otp_latch, user_latch, otp_press, user_press, sw_changed;
  logic [3:0] user_in;

  int errors = 0;
  int checks = 0;

  input_conditioner #(.DB_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rstn(rstn), .btn_otp_raw(btn_otp_raw), .btn_user_raw(btn_user_raw),
    .sw_raw(sw_raw), .otp_latch(otp_latch), .user_latch(user_latch),
    .otp_press(otp_press), .user_press(user_press), .user_in(user_in),
    .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  // Reference model. A value is accepted once the last DB+1 synchronised
  // samples all agree on it and it differs from the current output.
  // Synchronised sample at an edge = raw value sampled SS edges earlier.
  logic [3:0] rawh  [3][SS];
  logic [3:0] seenh [3][DB+1];
  int         seen_n [3];
  logic [3:0] m_stable [3];
  logic       m_chg [3];

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < SS; k++) rawh[c][k] = 4'h0;
      for (int k = 0; k <= DB; k++) seenh[c][k] = 4'h0;
      seen_n[c]   = 0;
      m_stable[c] = 4'h0;
      m_chg[c]    = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
    logic [3:0] rv [3];
    logic [3:0] seen;
    bit         same;
    rv[0] = r0; rv[1] = r1; rv[2] = r2;
    for (int c = 0; c < 3; c++) begin
      seen = rawh[c][0];
      for (int k = 0; k < SS - 1; k++) rawh[c][k] = rawh[c][k+1];
      rawh[c][SS-1] = rv[c];
      for (int k = 0; k < DB; k++) seenh[c][k] = seenh[c][k+1];
      seenh[c][DB] = seen;
      if (seen_n[c] < DB + 1) seen_n[c]++;
      m_chg[c] = 1'b0;
      if (seen_n[c] == DB + 1) begin
        same = 1'b1;
        for (int k = 0; k <= DB; k++) if (seenh[c][k] != seen) same = 1'b0;
        if (same && (seen != m_stable[c])) begin
          m_stable[c] = seen;
          m_chg[c]    = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rstn) model_edge({3'b0, btn_otp_raw}, {3'b0, btn_user_raw}, sw_raw);
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("otp_latch",  {3'b0, otp_latch},  m_stable[0]);
    chk("otp_press",  {3'b0, otp_press},  {3'b0, m_chg[0] & m_stable[0][0]});
    chk("user_latch", {3'b0, user_latch}, m_stable[1]);
    chk("user_press", {3'b0, user_press}, {3'b0, m_chg[1] & m_stable[1][0]});
    chk("user_in",    user_in,            m_stable[2]);
    chk("sw_changed", {3'b0, sw_changed}, {3'b0, m_chg[2]});
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {otp_latch, user_latch, otp_press, user_press}, 4'h0);
    chk(tag, user_in, 4'h0);
    chk(tag, {3'b0, sw_changed}, 4'h0);
  endtask

  // Advance n cycles; outputs are compared at each falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      check_model();
    end
  endtask

  int sw_chg_cnt;
  int press_cnt;
  bit bad_val;

  initial begin
    rstn = 1'b0; btn_otp_raw = 1'b0; btn_user_raw = 1'b0; sw_raw = 4'h0;
    model_reset();
    #1;
    check_all_zero("reset_state");
    cyc(2);
    rstn = 1'b1;
    cyc(3);

    // 1. Clean press and release of the user button.
    btn_user_raw = 1'b1;
    cyc(6);
    chk("t1_latch_before", {3'b0, user_latch}, 4'h0);
    cyc(1);
    chk("t1_latch_at6", {3'b0, user_latch}, 4'h1);
    chk("t1_press_at6", {3'b0, user_press}, 4'h1);
    cyc(1);
    chk("t1_press_oneshot", {3'b0, user_press}, 4'h0);
    cyc(12);
    btn_user_raw = 1'b0;
    press_cnt = 0;
    repeat (6) begin cyc(1); press_cnt += int'(user_press); end
    chk("t1_release_before", {3'b0, user_latch}, 4'h1);
    cyc(1); press_cnt += int'(user_press);
    chk("t1_release_at6", {3'b0, user_latch}, 4'h0);
    chk("t1_release_nostrobe", 4'(press_cnt), 4'h0);

    // 2. Bouncing OTP button, then held high.
    press_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      btn_otp_raw = ~btn_otp_raw;
      repeat (2) begin
        cyc(1);
        press_cnt += int'(otp_press);
        chk("t2_bounce_latch", {3'b0, otp_latch}, 4'h0);
      end
    end
    btn_otp_raw = 1'b1;
    repeat (6) begin cyc(1); press_cnt += int'(otp_press); end
    chk("t2_latch_before", {3'b0, otp_latch}, 4'h0);
    cyc(1); press_cnt += int'(otp_press);
    chk("t2_latch_at6", {3'b0, otp_latch}, 4'h1);
    repeat (4) begin cyc(1); press_cnt += int'(otp_press); end
    chk("t2_one_press", 4'(press_cnt), 4'h1);

    // 3. Glitch shorter than the debounce window.
    btn_user_raw = 1'b1;
    cyc(3);
    btn_user_raw = 1'b0;
    repeat (10) begin
      cyc(1);
      chk("t3_glitch", {2'b0, user_latch, user_press}, 4'h0);
    end

    // 4. Switch bus: clean change, then a short intermediate value.
    sw_raw = 4'hA;
    cyc(6);
    chk("t4_before", user_in, 4'h0);
    cyc(1);
    chk("t4_value", user_in, 4'hA);
    chk("t4_strobe", {3'b0, sw_changed}, 4'h1);
    cyc(5);
    sw_raw = 4'h3;
    cyc(2);
    sw_raw = 4'h5;
    sw_chg_cnt = 0;
    bad_val = 1'b0;
    repeat (12) begin
      cyc(1);
      sw_chg_cnt += int'(sw_changed);
      if (user_in != 4'hA && user_in != 4'h5) bad_val = 1'b1;
    end
    chk("t4_no_partial", {3'b0, bad_val}, 4'h0);
    chk("t4_one_change", 4'(sw_chg_cnt), 4'h1);
    chk("t4_final", user_in, 4'h5);

    // 5. Simultaneous presses.
    btn_otp_raw = 1'b0;
    cyc(10);
    btn_otp_raw = 1'b1; btn_user_raw = 1'b1;
    cyc(7);
    chk("t5_both_press", {2'b0, otp_press, user_press}, 4'h3);
    btn_otp_raw = 1'b0; btn_user_raw = 1'b0;
    cyc(10);

    // 6. Reset while a press is being counted.
    btn_otp_raw = 1'b1;
    cyc(5);
    rstn = 1'b0;
    #1;
    model_reset();
    check_all_zero("t6_reset_now");
    cyc(3);
    rstn = 1'b1;
    cyc(6);
    chk("t6_latch_before", {3'b0, otp_latch}, 4'h0);
    cyc(1);
    chk("t6_latch_at6", {3'b0, otp_latch}, 4'h1);
    chk("t6_press_at6", {3'b0, otp_press}, 4'h1);
    chk("t6_sw_restored", user_in, 4'h5);

    // Randomised phase: random holds mixing glitches and accepted changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) btn_otp_raw  = ~btn_otp_raw;
      if ($urandom_range(0, 3) == 0) btn_user_raw = ~btn_user_raw;
      if ($urandom_range(0, 4) == 0) sw_raw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 999) == 0) begin
        rstn = 1'b0;
        #1;
        model_reset();
        check_all_zero("rand_reset");
        cyc(2);
        rstn = 1'b1;
      end
      cyc($urandom_range(1, 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
